alu_mw_sequencer: RTL and testbench
===================================

# alu_mw_sequencer

Multi-word arithmetic/logic sequencer that acts as the initiator for the team's combinational 32-bit ALU (ops ADD=0, SUB=1, OR=2, AND=3, with carry-in and carry-out). It accepts one WORDS×32-bit operation over a valid/ready request channel and drives the ALU one 32-bit limb per cycle, least-significant first, chaining carry/borrow between limbs. It then returns the full-width result and final carry over a valid/ready response channel. It sits between a datapath controller and one ALU instance.

## Interface
- WORDS, 4, number of 32-bit limbs per operation (≥1)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_op  in  2  0 ADD, 1 SUB, 2 OR, 3 AND
- req_a  in  32*WORDS  operand A
- req_b  in  32*WORDS  operand B
- req_cin  in  1  initial carry (ADD) / borrow (SUB); ignored for OR/AND
- alu_ctrl  out  2  ALU op select
- alu_a  out  32  ALU operand A limb
- alu_b  out  32  ALU operand B limb
- alu_cin  out  1  ALU carry-in
- alu_res  in  32  ALU result (combinational from alu_* outputs)
- alu_cout  in  1  ALU carry/borrow out
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32*WORDS  full result
- rsp_cout  out  1  final carry (ADD) / borrow (SUB); 0 for OR/AND

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: req_ready=1. On req_valid: latch op, a, b, cin; idx←0; clear result register → RUN.
- RUN: alu_ctrl=op; alu_a/alu_b = limb idx of latched a/b; alu_cin = (op∈{OR,AND}) ? 0 : (idx==0 ? latched cin : carry_reg). Each edge: result[idx]←alu_res, carry_reg←alu_cout, idx←idx+1. When idx==WORDS-1 → DONE.
- DONE: rsp_valid=1; rsp_result and rsp_cout stable. On rsp_ready → IDLE.
- rsp_cout = carry_reg for ADD/SUB, forced 0 for OR/AND.
- SUB semantics: ALU gives {cout,res} = a−b−cin in 33 bits; cout=1 means borrow, which is chained as next limb's cin.
- Outside RUN: alu_ctrl, alu_a, alu_b, alu_cin driven 0.
- Request inputs are sampled only at the accept edge; later changes are ignored. req_valid outside IDLE is not accepted.
- WORDS=1: RUN lasts one cycle.

## Timing
- Reset (rst_n low, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_cout=0, alu_*=0, idx=0, carry_reg=0.
- Reset mid-RUN or in DONE aborts the operation immediately; no response is produced.
- Accept at edge E0. Limbs are captured at E1..E_WORDS. rsp_valid rises after E_WORDS, i.e. latency WORDS cycles.
- Response handshake at edge Ed → IDLE. Next accept is earliest Ed+1. Minimum op period is WORDS+2 cycles.
- rsp_valid, once high, stays high with stable data until rsp_ready is sampled high. Unbounded backpressure is allowed.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: extra output port rsp_zero (1 bit) = (rsp_result == 0), registered with the result, reset 0, valid while rsp_valid.
- ALU_SEQ_ZERO_FLAG_EN undefined: no rsp_zero port and no zero-detect logic.

## Test plan
- ADD, WORDS=4, a=0x00000000_00000000_00000000_FFFFFFFF, b=1, cin=0 → result 0x00000000_00000000_00000001_00000000, cout=0, rsp_valid exactly 4 cycles after accept.
- ADD a=all-ones (128b), b=1, cin=0 → result 0, cout=1; with ALU_SEQ_ZERO_FLAG_EN → rsp_zero=1.
- SUB a=0, b=1, cin=0 → result all-ones, cout=1. SUB a=5, b=3, cin=1 → result 1, cout=0.
- OR a=0xF0F0…, b=0x0F0F…, cin=1 → result all-ones, cout=0, alu_cin observed 0 every RUN cycle. AND of the same operands → 0, cout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 and changing req_* → rsp_result stable, req_ready=0, no second accept. Raise rsp_ready → IDLE next edge, new request accepted the cycle after.
- Drop rst_n during RUN at idx=2 → rsp_valid=0, alu_*=0, req_ready=1 immediately. After release, a fresh ADD 2+3 → result 5, cout=0.

Source files
------------

// File: rtl/alu_mw_sequencer.sv
// alu_mw_sequencer: sequences one WORDS x 32-bit ADD/SUB/OR/AND through a
// single 32-bit combinational ALU, one limb per cycle, least-significant first,
// chaining carry/borrow between limbs.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds the rsp_zero output.
module alu_mw_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [32*WORDS-1:0]   req_a,
  input  logic [32*WORDS-1:0]   req_b,
  input  logic                  req_cin,
  output logic [1:0]            alu_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic                  alu_cin,
  input  logic [31:0]           alu_res,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*WORDS-1:0]   rsp_result,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                  rsp_zero,
`endif
  output logic                  rsp_cout
);

  localparam int unsigned LIMB_W = 32;
  localparam int unsigned DATA_W = LIMB_W * WORDS;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                cin_q, cin_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                last_limb;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic                zero_q, zero_d;
`endif

  assign last_limb = (idx_q == IDX_W'(WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (last_limb) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched request, limb index, carry chain, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Datapath next values: capture request on accept, one limb per RUN cycle
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    if (state_q == IDLE && req_valid) begin
      op_d     = req_op;
      a_d      = req_a;
      b_d      = req_b;
      cin_d    = req_cin;
      idx_d    = '0;
      carry_d  = 1'b0;
      result_d = '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_d   = 1'b0;
`endif
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (idx_q == IDX_W'(i)) result_d[i*LIMB_W +: LIMB_W] = alu_res;
      end
      carry_d = alu_cout;
      idx_d   = last_limb ? '0 : idx_q + IDX_W'(1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      if (last_limb) zero_d = (result_d == '0);
`endif
    end
  end

  // Output decode from registered state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_ctrl  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      RUN: begin
        alu_ctrl = op_q;
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            alu_a = a_q[i*LIMB_W +: LIMB_W];
            alu_b = b_q[i*LIMB_W +: LIMB_W];
          end
        end
        // OR/AND (op[1]=1) never use a carry; limb 0 takes the request's cin
        if (!op_q[1]) alu_cin = (idx_q == '0) ? cin_q : carry_q;
      end
      DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_result = result_q;
  assign rsp_cout   = carry_q & ~op_q[1];
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_mw_sequencer.sv
// Self-checking bench for alu_mw_sequencer (WORDS=4) with a behavioural ALU
// and a full-width arithmetic reference model.
module tb_alu_mw_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic          req_cin;
  logic [1:0]    alu_ctrl;
  logic [31:0]   alu_a, alu_b, alu_res;
  logic          alu_cin, alu_cout;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          rsp_zero;
`endif

  int checks = 0;
  int passes = 0;

  alu_mw_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Combinational 32-bit ALU the sequencer drives
  logic [32:0] alu_sum;
  always_comb begin
    case (alu_ctrl)
      2'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_cin);
      2'd1:    alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - 33'(alu_cin);
      2'd2:    alu_sum = {1'b0, alu_a | alu_b};
      default: alu_sum = {1'b0, alu_a & alu_b};
    endcase
  end
  assign alu_res  = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_r;
    logic         exp_c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Whole-operand reference: one wide add/subtract, borrow is the extra bit
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic cin,
                                    output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    case (op)
      2'd0:    t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      2'd1:    t = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      2'd2:    t = {1'b0, a | b};
      default: t = {1'b0, a & b};
    endcase
    r = t[W-1:0];
    c = t[W];
  endfunction

  // Wait for rsp_valid (bounded), watching RUN-cycle ALU controls
  task automatic wait_rsp(input logic [1:0] op, output int lat,
                          output bit cin_bad, output bit ctrl_bad);
    lat = 0; cin_bad = 0; ctrl_bad = 0;
    while (!rsp_valid && lat < 64) begin
      if (op[1] && alu_cin !== 1'b0) cin_bad = 1;
      if (alu_ctrl !== op) ctrl_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full operation from IDLE: accept, run, check response, handshake
  task automatic check_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] exp_r, input logic exp_c);
    int lat;
    bit cin_bad, ctrl_bad;
    chk({nm, ".req_ready"}, W'(req_ready), W'(1));
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(posedge clk); #1;
    req_valid = 0;
    req_a = ~a; req_b = ~b; req_op = ~op; req_cin = ~cin;
    wait_rsp(op, lat, cin_bad, ctrl_bad);
    chk({nm, ".latency"}, W'(lat), W'(WORDS));
    chk({nm, ".result"}, rsp_result, exp_r);
    chk({nm, ".cout"}, W'(rsp_cout), W'(exp_c));
    chk({nm, ".alu_ctrl"}, W'(ctrl_bad), W'(0));
    if (op[1]) chk({nm, ".alu_cin_zero"}, W'(cin_bad), W'(0));
    chk({nm, ".alu_idle_done"}, W'({alu_ctrl, alu_a, alu_b, alu_cin}), W'(0));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({nm, ".zero"}, W'(rsp_zero), W'(exp_r == '0));
`endif
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, ".back_idle"}, W'({rsp_valid, req_ready}), W'(2'b01));
  endtask

  initial begin
    logic [W-1:0] r, x_r;
    logic         c, x_c;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    int           lat;
    bit           cb, kb;

    vecs[0] = '{2'd0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0,
                128'h00000000_00000000_00000001_00000000, 1'b0};
    vecs[1] = '{2'd0, {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1};
    vecs[2] = '{2'd1, 128'd0, 128'd1, 1'b0, {128{1'b1}}, 1'b1};
    vecs[3] = '{2'd1, 128'd5, 128'd3, 1'b1, 128'd1, 1'b0};
    vecs[4] = '{2'd2, {32{4'hF, 4'h0}}, {32{4'h0, 4'hF}}, 1'b1, {128{1'b1}}, 1'b0};
    vecs[5] = '{2'd3, {32{4'hF, 4'h0}}, {32{4'h0, 4'hF}}, 1'b1, 128'd0, 1'b0};
    vecs[6] = '{2'd0, 128'd2, 128'd3, 1'b0, 128'd5, 1'b0};

    rst_n = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_cin = 0; rsp_ready = 0;
    #12;
    chk("reset.ready_valid", W'({req_ready, rsp_valid}), W'(2'b10));
    chk("reset.result", rsp_result, '0);
    chk("reset.cout", W'(rsp_cout), W'(0));
    chk("reset.alu", W'({alu_ctrl, alu_a, alu_b, alu_cin}), W'(0));
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].exp_r, vecs[i].exp_c);

    // Backpressure: response held, request side ignored
    ref_model(2'd0, 128'h1234, 128'h1, 1'b0, r, c);
    req_valid = 1; req_op = 0; req_a = 128'h1234; req_b = 128'h1; req_cin = 0;
    @(posedge clk); #1;
    wait_rsp(2'd0, lat, cb, kb);
    chk("bp.latency", W'(lat), W'(WORDS));
    for (int i = 0; i < 10; i++) begin
      req_op = 2'($urandom); req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom}; req_cin = 1'($urandom);
      @(posedge clk); #1;
      chk("bp.hold", W'({rsp_valid, req_ready}), W'(2'b10));
      chk("bp.result", rsp_result, r);
    end
    req_op = 2'd1; req_a = 128'd100; req_b = 128'd58; req_cin = 1'b1;
    ref_model(2'd1, 128'd100, 128'd58, 1'b1, x_r, x_c);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("bp.release_idle", W'({rsp_valid, req_ready}), W'(2'b01));
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp.accept_next", W'(req_ready), W'(0));
    wait_rsp(2'd1, lat, cb, kb);
    chk("bp.next_latency", W'(lat), W'(WORDS));
    chk("bp.next_result", rsp_result, x_r);
    chk("bp.next_cout", W'(rsp_cout), W'(x_c));
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;

    // Reset in the middle of RUN at limb index 2
    req_valid = 1; req_op = 0; req_cin = 0;
    req_a = 128'h11111111_22222222_33333333_44444444;
    req_b = 128'h55555555_66666666_77777777_88888888;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid.limb2", W'(alu_a), W'(32'h22222222));
    rst_n = 0;
    #1;
    chk("rst_mid.ready_valid", W'({req_ready, rsp_valid}), W'(2'b10));
    chk("rst_mid.alu", W'({alu_ctrl, alu_a, alu_b, alu_cin}), W'(0));
    chk("rst_mid.result", rsp_result, '0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check_op("rst_mid.add", 2'd0, 128'd2, 128'd3, 1'b0, 128'd5, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      a   = {$urandom, $urandom, $urandom, $urandom};
      b   = {$urandom, $urandom, $urandom, $urandom};
      cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b = ~a;
        1: b = a;
        default: ;
      endcase
      ref_model(op, a, b, cin, r, c);
      check_op($sformatf("rand%0d", i), op, a, b, cin, r, c);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
